// File: rtl/cntr8_cmd_seq.sv
// cntr8_cmd_seq: FIFO-buffered command sequencer for the cntr8 datapath; optional saturation abort via CNTR8_SEQ_SAT_EN
module cntr8_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [3:0] cmd_rpt,
  input  logic       abort,
  input  logic [7:0] cnt_in,
  output logic [2:0] state,
  output logic [7:0] d_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sat
);
  typedef enum logic {S_WAIT, S_RUN} fsm_t;
  fsm_t fsm, fsm_n;
  logic [14:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  logic [3:0] rem, rem_n;
  logic [2:0] state_n, h_op;
  logic [7:0] d_n, h_data;
  logic [3:0] h_rpt;
  logic empty, full, legal, push, pop, last, wrap;
  assign {h_op, h_data, h_rpt} = mem[rp];
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign cmd_ready = !full;
  assign legal = cmd_op < 3'd6;
  assign push = cmd_valid && !full && legal && !abort;
`ifdef CNTR8_SEQ_SAT_EN
  assign wrap = fsm == S_RUN && ((state == 3'd2 && cnt_in == 8'hff) || (state == 3'd3 && cnt_in >= 8'hfe) ||
                                 (state == 3'd4 && cnt_in == 8'h00) || (state == 3'd5 && cnt_in <= 8'h01));
`else
  logic unused_cnt_in;
  assign unused_cnt_in = ^cnt_in;
  assign wrap = 1'b0;
`endif
  assign last = fsm == S_RUN && (rem == 4'd0 || wrap);
  assign pop = !empty && (fsm == S_WAIT || last) && !abort;
  assign done = last && !abort && !rst;
  assign sat = wrap && !abort && !rst;
  assign busy = fsm == S_RUN || !empty;
  // next command selection: abort flushes, pop loads, last cycle returns to idle, otherwise count down
  always_comb begin
    fsm_n = fsm;
    state_n = state;
    d_n = d_out;
    rem_n = rem;
    if (abort) begin
      fsm_n = S_WAIT;
      state_n = 3'd0;
      d_n = 8'h00;
      rem_n = 4'd0;
    end else if (pop) begin
      fsm_n = S_RUN;
      state_n = h_op;
      d_n = h_op == 3'd1 ? h_data : 8'h00;
      rem_n = h_op == 3'd1 ? 4'd0 : h_rpt;
    end else if (last) begin
      fsm_n = S_WAIT;
      state_n = 3'd0;
      d_n = 8'h00;
      rem_n = 4'd0;
    end else if (fsm == S_RUN) begin
      rem_n = rem - 4'd1;
    end
  end
  // FSM, output registers and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= S_WAIT;
      state <= 3'd0;
      d_out <= 8'h00;
      rem <= 4'd0;
      err <= 1'b0;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      fsm <= fsm_n;
      state <= state_n;
      d_out <= d_n;
      rem <= rem_n;
      err <= cmd_valid && !full && !legal && !abort;
      if (abort) begin
        rp <= '0;
        wp <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  // FIFO storage, written only on an accepted legal command
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {cmd_op, cmd_data, cmd_rpt};
  end
endmodule

// File: tb/tb_cntr8_cmd_seq.sv
// tb_cntr8_cmd_seq: table vectors, directed corner cases and random stimulus against a command-queue model
module tb_cntr8_cmd_seq;
  logic clk = 0, rst = 1, cmd_valid = 0, abort = 0;
  logic [2:0] cmd_op = 0;
  logic [7:0] cmd_data = 0;
  logic [3:0] cmd_rpt = 0;
  logic [7:0] cnt_in, seed = 8'h80;
  logic emu = 0;
  logic cmd_ready, busy, done, err, sat;
  logic [2:0] state;
  logic [7:0] d_out;
  int n_cmp = 0, n_bad = 0;

  cntr8_cmd_seq #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_rpt(cmd_rpt), .abort(abort), .cnt_in(cnt_in), .state(state),
    .d_out(d_out), .busy(busy), .done(done), .err(err), .sat(sat)
  );

  always #5 clk = ~clk;

  // emulated counter datapath for the saturation run
  always @(posedge clk)
    cnt_in <= !emu ? seed : state == 3'd1 ? d_out : state == 3'd2 ? cnt_in + 8'd1 : state == 3'd3 ? cnt_in + 8'd2 :
              state == 3'd4 ? cnt_in - 8'd1 : state == 3'd5 ? cnt_in - 8'd2 : cnt_in;

  // model: queued commands, and the per-cycle {op,data} codes of the running command
  logic [14:0] mq[$];
  logic [10:0] cur[$];
  logic m_err = 0;

  task automatic model_step();
    logic can;
    logic [14:0] c;
    if (rst) begin
      mq.delete(); cur.delete(); m_err = 0;
    end else begin
      can = mq.size() < 4;
      m_err = cmd_valid && can && cmd_op >= 3'd6 && !abort;
      if (abort) begin
        mq.delete(); cur.delete();
      end else begin
        if (cur.size() > 0) void'(cur.pop_front());
        if (cur.size() == 0 && mq.size() > 0) begin
          c = mq.pop_front();
          if (c[14:12] == 3'd1) cur.push_back({3'd1, c[11:4]});
          else for (int i = 0; i <= int'(c[3:0]); i++) cur.push_back({c[14:12], 8'h00});
        end
        if (cmd_valid && can && cmd_op < 3'd6) mq.push_back({cmd_op, cmd_data, cmd_rpt});
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_state", 32'(state), cur.size() > 0 ? 32'(cur[0][10:8]) : 0);
    chk("m_dout", 32'(d_out), cur.size() > 0 ? 32'(cur[0][7:0]) : 0);
    chk("m_done", 32'(done), 32'(cur.size() == 1 && !abort && !rst));
    chk("m_busy", 32'(busy), 32'(cur.size() > 0 || mq.size() > 0));
    chk("m_ready", 32'(cmd_ready), 32'(mq.size() < 4));
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_sat", 32'(sat), 0);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] d, input logic [3:0] r, input logic a);
    cmd_valid = v; cmd_op = o; cmd_data = d; cmd_rpt = r; abort = a;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct packed {
    logic v; logic [2:0] op; logic [7:0] d; logic [3:0] r;
    logic [2:0] es; logic [7:0] ed; logic edn, eb, eerr;
  } vec_t;
  vec_t tbl [13];

`ifdef CNTR8_SEQ_SAT_EN
  localparam int EXP_N3 = 2, EXP_NS = 1;
`else
  localparam int EXP_N3 = 6, EXP_NS = 0;
`endif

  initial begin
    int fall_k, rise_k, idx, n3, ns, nd, nsx;
    logic hs;
    logic [7:0] cops [6];
    logic [3:0] crpt [6];
    tbl[0]  = '{1'b1, 3'd1, 8'h3c, 4'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd1, 8'h3c, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'd2, 8'haa, 4'd3, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 3'd5, 8'haa, 4'd1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd2, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd5, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 3'd6, 8'h55, 4'd2, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 8'h00, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    rst = 1;
    cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_dout", 32'(d_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].r, 1'b0);
      cyc();
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_dout", i), 32'(d_out), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].edn));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].eerr));
    end
    cops = '{8'd2, 8'd2, 8'd4, 8'd3, 8'd5, 8'd0};
    crpt = '{4'd15, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0};
    idx = 0; fall_k = -1; rise_k = -1;
    for (int k = 0; k < 40 && idx < 6; k++) begin
      drive(1'b1, cops[idx][2:0], 8'h11, crpt[idx], 1'b0);
      hs = cmd_ready;
      cyc();
      chk_model();
      if (hs) idx++;
      if (!cmd_ready && fall_k < 0) fall_k = k;
      if (cmd_ready && fall_k >= 0 && rise_k < 0) rise_k = k;
    end
    chk("full_fall_cycle", 32'(fall_k), 4);
    chk("full_rise_cycle", 32'(rise_k), 17);
    drive(1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    for (int k = 0; k < 40 && busy; k++) begin cyc(); chk_model(); end
    chk("drain_busy", 32'(busy), 0);
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, 3'd2, 8'h00, 4'd8, 1'b0); cyc(); chk_model();
      drive(1'b1, 3'd4, 8'h00, 4'd2, 1'b0); cyc(); chk_model();
      drive(1'b1, 3'd1, 8'h77, 4'd0, 1'b0); cyc(); chk_model();
      drive(1'b0, 3'd0, 8'h00, 4'd0, 1'b0); cyc(); chk_model();
      drive(1'b1, 3'd3, 8'h00, 4'd1, t == 0);
      rst = t == 1;
      cyc();
      chk_model();
      chk($sformatf("flush%0d_state", t), 32'(state), 0);
      chk($sformatf("flush%0d_busy", t), 32'(busy), 0);
      chk($sformatf("flush%0d_done", t), 32'(done), 0);
      chk($sformatf("flush%0d_ready", t), 32'(cmd_ready), 1);
      rst = 0;
      drive(1'b0, 3'd0, 8'h00, 4'd0, 1'b0); cyc(); chk_model();
      chk($sformatf("flush%0d_after_busy", t), 32'(busy), 0);
    end
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom_range(0, 3)),
            $urandom_range(0, 39) == 0);
      cyc();
      chk_model();
    end
    rst = 1; drive(1'b0, 3'd0, 8'h00, 4'd0, 1'b0); cyc(); rst = 0;
    seed = 8'hfd; cyc();
    drive(1'b1, 3'd3, 8'h00, 4'd5, 1'b0);
    cyc();
    drive(1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    emu = 1;
    n3 = 0; ns = 0; nd = 0; nsx = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (state == 3'd3) n3++;
      if (sat) ns++;
      if (done) nd++;
      if (sat != done) nsx++;
    end
    chk("sat_cycles", 32'(n3), 32'(EXP_N3));
    chk("sat_pulses", 32'(ns), 32'(EXP_NS));
    chk("sat_done", 32'(nd), 1);
    if (EXP_NS > 0) chk("sat_with_done", 32'(nsx), 0);
    chk("sat_end_state", 32'(state), 0);
    emu = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
